// File: rtl/int_arith_pkg.sv
// Shared types and constants for the integer arithmetic datapath.
package int_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int unsigned DEFAULT_CHUNK_WIDTH = 8;

endpackage

// File: rtl/chunk_sub_cell.sv
// One CHUNK_WIDTH-wide subtract slice with borrow in/out.
module chunk_sub_cell #(
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] a_chunk,
  input  logic [CHUNK_WIDTH-1:0] b_chunk,
  input  logic                   borrow_in,
  output logic [CHUNK_WIDTH-1:0] diff_chunk,
  output logic                   borrow_out
);

  logic [CHUNK_WIDTH:0] ext;

  // The extra MSB goes high exactly when the slice result is negative.
  assign ext        = (CHUNK_WIDTH+1)'(a_chunk) - (CHUNK_WIDTH+1)'(b_chunk)
                    - (CHUNK_WIDTH+1)'(borrow_in);
  assign diff_chunk = ext[CHUNK_WIDTH-1:0];
  assign borrow_out = ext[CHUNK_WIDTH];

endmodule

// File: rtl/chunked_sub_seq.sv
// Multi-cycle unsigned subtractor, one chunk per cycle, LSB first.
// Define CHUNKED_SUB_SAT_EN for saturating (clamp-to-zero) subtraction.
module chunked_sub_seq
  import int_arith_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK_WIDTH;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("chunked_sub_seq: WIDTH must be a multiple of CHUNK_WIDTH");
  end

  sub_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   borrow_q, borrow_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic                   borrow_out_q, borrow_out_d;
  logic                   zero_q, zero_d;
  logic                   out_valid_q, out_valid_d;

  logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, diff_chunk;
  logic                   cell_borrow;

  chunk_sub_cell #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_cell (
    .a_chunk    (a_chunk),
    .b_chunk    (b_chunk),
    .borrow_in  (borrow_q),
    .diff_chunk (diff_chunk),
    .borrow_out (cell_borrow)
  );

  // Operand chunk select for the current index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk = b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    out_valid_d  = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
          if (idx_q == IDX_W'(i)) diff_d[i*CHUNK_WIDTH +: CHUNK_WIDTH] = diff_chunk;
        end
        borrow_d = cell_borrow;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CHUNKS - 1)) begin
          idx_d        = '0;
          borrow_out_d = cell_borrow;
`ifdef CHUNKED_SUB_SAT_EN
          if (cell_borrow) diff_d = '0;
`endif
          zero_d       = (diff_d == '0);
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule

// File: doc/chunked_sub_seq.md
Name: chunked_sub_seq

Overview:
- Multi-cycle unsigned integer subtractor for the int datapath. It computes a - b one CHUNK_WIDTH slice per cycle, LSB chunk first, with a registered borrow chain.
- Companion to the carry-select chunked adder. It trades latency for a short critical path.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK_WIDTH, 8, bits processed per cycle. WIDTH % CHUNK_WIDTH != 0 is an elaboration error.
- NUM_CHUNKS (localparam), WIDTH/CHUNK_WIDTH, number of BUSY cycles per operation.

Ports:
- clk  in  1  clock, all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  out  1  final borrow, i.e. a < b unsigned.
- zero  out  1  diff == 0.

Behaviour:
- Reset values: state = IDLE, out_valid = 0, diff = 0, borrow_out = 0, zero = 0, chunk index = 0, borrow register = 0.
- in_ready = (state == IDLE), driven combinationally from state. It is 1 on the first cycle after reset.
- FSM state IDLE:
  - On in_valid && in_ready: latch a and b, clear idx and borrow, go to BUSY.
- FSM state BUSY:
  - Each cycle, chunk idx = (a_chunk - b_chunk - borrow). Write the CHUNK_WIDTH result into diff[idx] and register the chunk borrow.
  - idx increments each cycle. After the idx == NUM_CHUNKS-1 cycle, go to DONE.
  - Set borrow_out to the final borrow and zero to (full diff == 0).
- FSM state DONE:
  - out_valid = 1. diff, borrow_out and zero are held stable.
  - On out_ready: go to IDLE and clear out_valid.
- Latency: with operands accepted at edge k, out_valid rises after edge k + NUM_CHUNKS.
- Throughput: one result per NUM_CHUNKS + 2 cycles minimum. There is no accept during DONE.
- Backpressure: out_ready low in DONE holds all outputs indefinitely.
- in_valid while not IDLE is ignored. a and b are sampled only on the accept edge.
- Reset asserted in any state aborts the operation. The in-flight result is discarded and never emitted, and all outputs return to reset values on the next edge.
- NUM_CHUNKS == 1 (CHUNK_WIDTH == WIDTH): BUSY lasts exactly one cycle.
- diff keeps its previous value in IDLE. It is only meaningful while out_valid is high.

Optional Feature:
- Macro: CHUNKED_SUB_SAT_EN.
- When defined: unsigned saturating subtract. If the final borrow is 1, diff is forced to 0 and zero = 1 on entry to DONE. borrow_out still reports 1.
- When undefined: wrap-around modulo 2^WIDTH, and zero reflects the wrapped value.
- Latency and handshake are identical in both builds.

Decomposition:
- Package int_arith_pkg holds:
  - typedef enum sub_state_t {IDLE, BUSY, DONE}.
  - Shared constant DEFAULT_CHUNK_WIDTH = 8.
- Sub-module chunk_sub_cell: combinational, CHUNK_WIDTH-wide.
  - Inputs: a_chunk, b_chunk, borrow_in.
  - Outputs: diff_chunk, borrow_out.
  - The top level instantiates it once and time-multiplexes it over chunks.

Test Plan:
- a=0x00000005, b=0x00000003, accepted at edge 0 -> out_valid after edge 4, diff=0x00000002, borrow_out=0, zero=0.
- a=0x00000100, b=0x00000001 -> diff=0x000000FF, borrow_out=0. This exercises cross-chunk borrow propagation.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow_out=1. With CHUNKED_SUB_SAT_EN: diff=0, zero=1, borrow_out=1.
- a=b=0xDEADBEEF -> diff=0, zero=1, borrow_out=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE; pulse in_valid with a=7, b=1 during that time.
  - Response: diff, borrow_out and zero are stable; in_ready=0; the new operands are ignored.
  - After out_ready=1: IDLE next cycle, in_ready=1.
- Reset on the 3rd BUSY cycle:
  - Response: next cycle out_valid=0, in_ready=1, diff=0, and no result is emitted.
  - A fresh a=9, b=4 then yields diff=5 with normal latency.
